// File: rtl/sens_hispi_read_sched_pkg.sv
// sens_hispi_read_sched_pkg: shared definitions for the HiSPi read-side scheduler.
//   state_t  : scheduler FSM states
//   idx_bits : bits needed to count/index n items (minimum 1)
package sens_hispi_read_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ALL,
        ST_READ,
        ST_DONE
    } state_t;

    function automatic int idx_bits(input int n);
        int b = 1;
        while ((1 << b) < n) b++;
        return b;
    endfunction

endpackage

// File: rtl/sens_hispi_rr_lane.sv
// sens_hispi_rr_lane: round-robin lane index, one-hot read enable and lane_sel pipeline.
//   clk, rstn : clock and synchronous active-low reset
//   clr       : hold the lane index at 0 (outside of line reads)
//   adv       : issue a read to the current lane and step to the next one
//   idx       : lane that the next read will target
//   re        : registered one-hot read enable
//   lane_sel  : index of the previous cycle's read, aligned with hact
module sens_hispi_rr_lane
    import sens_hispi_read_sched_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int LANE_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic                 adv,
    output logic [LANE_BITS-1:0] idx,
    output logic [NUM_LANES-1:0] re,
    output logic [LANE_BITS-1:0] lane_sel
);

    logic [LANE_BITS-1:0] re_idx;
    logic                 wrap;

    assign wrap = idx == LANE_BITS'(NUM_LANES - 1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx      <= '0;
            re       <= '0;
            re_idx   <= '0;
            lane_sel <= '0;
        end else begin
            idx      <= clr ? '0 : adv ? (wrap ? '0 : idx + 1'b1) : idx;
            re       <= adv ? NUM_LANES'(1) << idx : '0;
            re_idx   <= adv ? idx : re_idx;
            lane_sel <= re_idx;
        end
    end

endmodule

// File: rtl/sens_hispi_read_sched.sv
// sens_hispi_read_sched: read scheduler for a bank of per-lane HiSPi line FIFOs.
//   pclk, prstn  : pixel clock, synchronous active-low reset
//   en           : allow a new line to start (looked at in IDLE only)
//   fsync        : frame start, clears line_cntr
//   line_pixels  : pixels per line over all lanes (0 means 2^PIX_BITS)
//   run          : per-lane FIFO "line ready / draining"
//   re           : one-hot FIFO read enable, data valid the next cycle
//   lane_sel     : lane whose data is valid, aligned with hact
//   hact/sol/eol : pixel valid, start-of-line and end-of-line framing
//   line_cntr    : lines completed since fsync
//   err_*        : sticky timeout / underrun / overrun flags, cleared by err_clr
module sens_hispi_read_sched
    import sens_hispi_read_sched_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int LANE_BITS = 2,
    parameter int PIX_BITS  = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 pclk,
    input  logic                 prstn,
    input  logic                 en,
    input  logic                 fsync,
    input  logic [PIX_BITS-1:0]  line_pixels,
    input  logic [NUM_LANES-1:0] run,
    output logic [NUM_LANES-1:0] re,
    output logic [LANE_BITS-1:0] lane_sel,
    output logic                 hact,
    output logic                 sol,
    output logic                 eol,
    output logic [PIX_BITS-1:0]  line_cntr,
    output logic                 err_timeout,
    output logic                 err_underrun,
    output logic                 err_overrun,
    input  logic                 err_clr
);

    localparam int TW = idx_bits(TIMEOUT + 1);

    state_t               state;
    logic [TW-1:0]        tmo;
    logic [PIX_BITS-1:0]  len;
    logic [PIX_BITS-1:0]  cnt;
    logic [LANE_BITS-1:0] idx;
    logic                 first_q;
    logic                 last_q;
    logic                 abort_q;
    logic                 lane_ok;
    logic                 issue;
    logic                 last_pix;
    logic                 tmo_hit;
    logic                 set_to;
    logic                 set_ur;
    logic                 set_ov;

    // Reads are decided one cycle ahead and registered, so run never reaches re combinationally.
    assign lane_ok  = run[idx];
    assign issue    = (state == ST_READ) && lane_ok;
    // Wrapping subtraction makes len=0 behave as 2^PIX_BITS pixels.
    assign last_pix = cnt == len - PIX_BITS'(1);
    assign tmo_hit  = tmo == TW'(TIMEOUT - 1);
    assign set_to   = (state == ST_WAIT_ALL) && !(&run) && tmo_hit;
    assign set_ur   = (state == ST_READ) && !lane_ok;
    assign set_ov   = (state == ST_DONE) && (|run) && tmo_hit;

    sens_hispi_rr_lane #(
        .NUM_LANES(NUM_LANES),
        .LANE_BITS(LANE_BITS)
    ) u_lane (
        .clk     (pclk),
        .rstn    (prstn),
        .clr     (state != ST_READ),
        .adv     (issue),
        .idx     (idx),
        .re      (re),
        .lane_sel(lane_sel)
    );

    always_ff @(posedge pclk) begin
        if (!prstn) begin
            state        <= ST_IDLE;
            tmo          <= '0;
            len          <= '0;
            cnt          <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            abort_q      <= 1'b0;
            hact         <= 1'b0;
            sol          <= 1'b0;
            eol          <= 1'b0;
            line_cntr    <= '0;
            err_timeout  <= 1'b0;
            err_underrun <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            // first_q/last_q/abort_q travel alongside re; hact/sol/eol are the next stage.
            first_q      <= issue && (cnt == '0);
            last_q       <= issue && last_pix;
            abort_q      <= set_ur;
            hact         <= |re;
            sol          <= first_q;
            eol          <= last_q || abort_q;
            line_cntr    <= fsync ? '0 : line_cntr + PIX_BITS'(eol);
            err_timeout  <= set_to || (err_timeout && !err_clr);
            err_underrun <= set_ur || (err_underrun && !err_clr);
            err_overrun  <= set_ov || (err_overrun && !err_clr);
            case (state)
                ST_IDLE: begin
                    if (en && |run) begin
                        state <= ST_WAIT_ALL;
                        tmo   <= '0;
                    end
                end
                ST_WAIT_ALL: begin
                    if (&run) begin
                        state <= ST_READ;
                        len   <= line_pixels;
                        cnt   <= '0;
                    end else if (tmo_hit) begin
                        state <= ST_DONE;
                        tmo   <= '0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                ST_READ: begin
                    cnt <= cnt + 1'b1;
                    if (!lane_ok || last_pix) begin
                        state <= ST_DONE;
                        tmo   <= '0;
                    end
                end
                ST_DONE: begin
                    if (!(|run) || tmo_hit) state <= ST_IDLE;
                    else tmo <= tmo + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sens_hispi_read_sched.sv
// tb_sens_hispi_read_sched: scoreboard bench for the HiSPi read scheduler.
// Lane FIFOs are modelled as word counts; run drops one cycle after a lane's last read.
module tb_sens_hispi_read_sched;

    localparam int NL = 4;
    localparam int LB = 2;
    localparam int PB = 16;
    localparam int TO = 255;

    typedef struct packed {
        logic          hact;
        logic          sol;
        logic          eol;
        logic [LB-1:0] lane;
    } beat_t;

    logic          pclk = 1'b0;
    logic          prstn = 1'b0;
    logic          en = 1'b0;
    logic          fsync = 1'b0;
    logic          err_clr = 1'b0;
    logic [PB-1:0] line_pixels = '0;
    logic [NL-1:0] run = '0;
    logic [NL-1:0] re;
    logic [LB-1:0] lane_sel;
    logic          hact;
    logic          sol;
    logic          eol;
    logic [PB-1:0] line_cntr;
    logic          err_timeout;
    logic          err_underrun;
    logic          err_overrun;

    beat_t exp_q[$];
    beat_t mon_got;
    beat_t mon_exp;
    int    avail[NL];
    int    words[NL];
    int    n_chk = 0;
    int    n_fail = 0;
    int    lc_model = 0;

    always #5 pclk = ~pclk;

    sens_hispi_read_sched #(
        .NUM_LANES(NL),
        .LANE_BITS(LB),
        .PIX_BITS (PB),
        .TIMEOUT  (TO)
    ) dut (
        .pclk        (pclk),
        .prstn       (prstn),
        .en          (en),
        .fsync       (fsync),
        .line_pixels (line_pixels),
        .run         (run),
        .re          (re),
        .lane_sel    (lane_sel),
        .hact        (hact),
        .sol         (sol),
        .eol         (eol),
        .line_cntr   (line_cntr),
        .err_timeout (err_timeout),
        .err_underrun(err_underrun),
        .err_overrun (err_overrun),
        .err_clr     (err_clr)
    );

    task automatic chk(input string name, input longint got, input longint want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every framing output event must match the next expected beat.
    always @(negedge pclk) begin
        if (prstn && (hact || sol || eol)) begin
            mon_got = beat_t'({hact, sol, eol, hact ? lane_sel : LB'(0)});
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", mon_got, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("beat", mon_got, mon_exp);
            end
        end
    end

    // One cycle of the lane FIFO model, evaluated at the falling edge.
    task automatic tick();
        @(negedge pclk);
        if (re != '0) chk("re_onehot", $countones(re), 1);
        for (int l = 0; l < NL; l++) begin
            run[l] = avail[l] > 0;
            if (re[l]) begin
                chk("re_lane_has_data", avail[l] > 0, 1);
                if (avail[l] > 0) avail[l]--;
            end
        end
    endtask

    task automatic load_lanes();
        for (int l = 0; l < NL; l++) begin
            avail[l] = words[l];
            run[l]   = words[l] > 0;
        end
    endtask

    task automatic flush_lanes();
        for (int l = 0; l < NL; l++) begin
            avail[l] = 0;
            run[l]   = 1'b0;
        end
    endtask

    function automatic bit lanes_empty();
        for (int l = 0; l < NL; l++) if (avail[l] != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: reads go to lane i%NL; a lane that has run out aborts the line.
    task automatic model_line(input int len, input bit fs, output bit to_e, output bit ur_e, output bit ov_e);
        int used[NL];
        beat_t b;
        to_e = 1'b0;
        ur_e = 1'b0;
        ov_e = 1'b0;
        for (int l = 0; l < NL; l++) if (words[l] == 0) to_e = 1'b1;
        if (!to_e) begin
            for (int i = 0; i < len; i++) begin
                int j;
                j = i % NL;
                if (used[j] >= words[j]) begin
                    ur_e = 1'b1;
                    b = beat_t'({1'b0, 1'b0, 1'b1, LB'(0)});
                    exp_q.push_back(b);
                    break;
                end
                used[j]++;
                b = beat_t'({1'b1, i == 0, i == len - 1, LB'(j)});
                exp_q.push_back(b);
            end
            for (int l = 0; l < NL; l++) if (used[l] < words[l]) ov_e = 1'b1;
            lc_model = fs ? 0 : (lc_model + 1) % (1 << PB);
        end
    endtask

    task automatic run_line(input int len, input bit fs_on_eol, input int clr_edge);
        bit to_e, ur_e, ov_e;
        bit done = 1'b0;
        int c = 0;
        int t_to = -1;
        model_line(len, fs_on_eol, to_e, ur_e, ov_e);
        line_pixels = PB'(len);
        en = 1'b1;
        load_lanes();
        while (!done && c < 900) begin
            tick();
            c++;
            if (c == 2) en = 1'b0;
            err_clr = clr_edge > 0 && c >= clr_edge - 11 && c < clr_edge;
            if (fs_on_eol) fsync = eol;
            if (err_timeout && t_to < 0) t_to = c;
            done = to_e ? err_timeout : ov_e ? err_overrun : (lanes_empty() && exp_q.size() == 0);
        end
        chk("line_finished", done, 1);
        if (to_e) chk("timeout_latency", t_to, TO + 1);
        err_clr = 1'b0;
        flush_lanes();
        repeat (5) begin
            tick();
            fsync = 1'b0;
        end
        chk("err_timeout", err_timeout, to_e);
        chk("err_underrun", err_underrun, ur_e);
        chk("err_overrun", err_overrun, ov_e);
        chk("line_cntr", line_cntr, lc_model);
        chk("beats_consumed", exp_q.size(), 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        chk("err_cleared", {err_timeout, err_underrun, err_overrun}, 0);
    endtask

    initial begin
        bit to_e, ur_e, ov_e;
        repeat (3) tick();
        chk("rst_re", re, 0);
        chk("rst_hact", hact, 0);
        chk("rst_sol_eol", {sol, eol}, 0);
        chk("rst_lane_sel", lane_sel, 0);
        chk("rst_line_cntr", line_cntr, 0);
        chk("rst_errors", {err_timeout, err_underrun, err_overrun}, 0);
        prstn = 1'b1;
        repeat (2) tick();

        words = '{4, 4, 4, 4};
        run_line(16, 1'b0, 0);
        words = '{3, 3, 2, 2};
        run_line(10, 1'b0, 0);
        words = '{1, 1, 1, 1};
        run_line(1, 1'b0, 0);
        words = '{4, 4, 4, 0};
        run_line(16, 1'b0, 0);
        words = '{2, 2, 1, 1};
        run_line(16, 1'b0, 0);
        words = '{5, 5, 5, 5};
        run_line(16, 1'b0, 2 + 16 + TO);
        words = '{2, 2, 2, 2};
        run_line(8, 1'b1, 0);

        // Reset in the middle of a line.
        words = '{8, 8, 8, 8};
        model_line(32, 1'b0, to_e, ur_e, ov_e);
        line_pixels = PB'(32);
        en = 1'b1;
        load_lanes();
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 2) en = 1'b0;
        end
        prstn = 1'b0;
        tick();
        chk("midrst_re", re, 0);
        chk("midrst_hact", hact, 0);
        chk("midrst_line_cntr", line_cntr, 0);
        prstn = 1'b1;
        exp_q.delete();
        flush_lanes();
        lc_model = 0;
        repeat (6) tick();
        chk("post_rst_idle_re", re, 0);

        for (int n = 0; n < 20; n++) begin
            int len, mode, l;
            len  = $urandom_range(1, 40);
            mode = $urandom_range(0, 3);
            for (int k = 0; k < NL; k++) begin
                words[k] = (len > k) ? (len - k + NL - 1) / NL : 0;
                if (words[k] == 0) words[k] = 1;
            end
            l = $urandom_range(0, NL - 1);
            if (mode == 0 && words[l] >= 2) words[l] = $urandom_range(1, words[l] - 1);
            if (mode == 1) words[l] += $urandom_range(1, 3);
            if ($urandom_range(0, 4) == 0) begin
                fsync = 1'b1;
                tick();
                fsync = 1'b0;
                lc_model = 0;
                chk("fsync_clear", line_cntr, 0);
            end
            run_line(len, 1'b0, 0);
        end

        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sens_hispi_read_sched.md
Name: sens_hispi_read_sched

Overview:
- Read-side scheduler for a bank of per-lane HiSPi cross-clock line FIFOs.
- Each FIFO reports `run` (a line is ready or draining) and accepts `re` (data valid the cycle after `re`).
- The block waits until every lane has a line ready, then reads the lanes round-robin, one `re` per cycle.
- It produces the pixel-rate output framing (`hact`, `sol`, `eol`, lane select) for the sensor channel and flags line-length and lane-alignment errors.

Parameters:
- NUM_LANES, 4: number of lane FIFOs; must be 2..8.
- LANE_BITS, 2: width of the lane index; must satisfy 2^LANE_BITS >= NUM_LANES.
- PIX_BITS, 16: width of the pixel counter and of `line_pixels`.
- TIMEOUT, 255: pclk cycles allowed in WAIT_ALL and in DONE before an error is raised.

Ports:
- pclk  in  1  pixel clock (the only clock).
- prstn  in  1  synchronous reset, active-low.
- en  in  1  enables starting new lines; sampled in IDLE only.
- fsync  in  1  frame start pulse; clears `line_cntr`.
- line_pixels  in  PIX_BITS  pixels per line, summed over all lanes; sampled on WAIT_ALL->READ; 0 means 2^PIX_BITS.
- run  in  NUM_LANES  per-lane FIFO `run`.
- re  out  NUM_LANES  one-hot read enable, at most one bit set per cycle.
- lane_sel  out  LANE_BITS  lane whose `dout` is valid this cycle; aligned with `hact`.
- hact  out  1  pixel valid; equals `re` delayed by one cycle.
- sol  out  1  one-cycle pulse, coincident with the first `hact` of a line.
- eol  out  1  one-cycle pulse, coincident with the last `hact` of a line, or the abort cycle.
- line_cntr  out  PIX_BITS  lines completed since `fsync`.
- err_timeout  out  1  sticky flag.
- err_underrun  out  1  sticky flag.
- err_overrun  out  1  sticky flag.
- err_clr  in  1  clears all sticky flags.

Behaviour:
- Reset (`prstn`=0, synchronous):
  - state IDLE;
  - `re`=0, `hact`=0, `sol`=0, `eol`=0, `lane_sel`=0, `line_cntr`=0, all error flags 0;
  - internal counters 0.
- IDLE:
  - `en`=1 and `run` != 0 -> WAIT_ALL; the timeout counter is loaded with 0.
  - `en`=0 holds IDLE regardless of `run`.
- WAIT_ALL:
  - all `run` bits 1 -> READ; latch `line_pixels`; lane index=0; pixel count=0.
  - timeout counter reaching TIMEOUT -> set `err_timeout`, go to DONE; no `re` is issued for that line.
- READ, every cycle:
  - `re`=one-hot(lane index); lane index increments mod NUM_LANES; pixel count increments.
  - On the cycle `pixel count == latched_len-1` the last `re` is issued, then DONE.
  - A partial final round is allowed: `latched_len` need not be a multiple of NUM_LANES.
  - Underrun: if `run[lane index]`=0 when an `re` would issue, that `re` is suppressed, `err_underrun` is set, and the state goes to DONE. `eol` pulses on the following cycle with `hact`=0; `line_cntr` still increments.
- Output pipeline (one register stage):
  - `hact`(t+1)=|`re`(t); `lane_sel`(t+1)=index of `re`(t).
  - `sol` = `hact` of the first `re` of the line.
  - `eol` = `hact` of the last `re` of the line.
  - Single-pixel line (`latched_len`=1): `sol` and `eol` are asserted on the same cycle.
- DONE:
  - waits for `run`==0 on all lanes (FIFO `run` drops one cycle after its last `re`);
  - then IDLE.
  - Timeout counter reaching TIMEOUT with any `run` still 1 -> set `err_overrun` (the FIFO holds more data than `line_pixels`), then IDLE. The residue is discarded by the FIFO's next start-of-line.
- `line_cntr`:
  - increments once per `eol`, wraps at 2^PIX_BITS;
  - `fsync` clears it; `fsync` together with `eol` -> result 0.
- Sticky errors: `err_clr` clears them; a set in the same cycle as `err_clr` wins.
- `en` dropping mid-line does not abort the line; it only blocks the next IDLE exit.
- WAIT_ALL->READ is taken one cycle after all `run` bits are seen high. There is no combinational path from `run` to `re`.

Decomposition:
- Shared package:
  - state encoding (IDLE, WAIT_ALL, READ, DONE);
  - `clog2`-style helper for LANE_BITS.
- Sub-module `sens_hispi_rr_lane`:
  - lane index counter with wrap at NUM_LANES;
  - one-hot decoder;
  - registered `lane_sel` stage.
- The FSM, counters and error logic stay in the top.

Test Plan:
- NUM_LANES=4, `line_pixels`=16, all `run` rise together and stay high through the last `re` ->
  - `re` cycles 0001,0010,0100,1000 four times;
  - `hact` for 16 cycles; `sol` on cycle 1 and `eol` on cycle 16 of `hact`;
  - `line_cntr`=1, no errors.
- `line_pixels`=10 -> final round reads lanes 0,1 only; `eol` with `lane_sel`=1; 10 `hact` cycles.
- Lane 3 `run` stays low, TIMEOUT=255 -> `err_timeout` set 255 cycles after WAIT_ALL entry; zero `re`; return to IDLE after all `run` low.
- Lane 2 `run` drops at pixel 6 -> no `re` to lane 2; `err_underrun` set; `eol` with `hact`=0; `line_cntr` +1.
- All `run` held high 300 cycles after the last `re` -> `err_overrun`; `err_clr` together with a new `err_overrun` set -> flag remains 1.
- `prstn` low mid-READ -> next cycle `re`=0, `hact`=0, state IDLE, counters 0; `fsync` while `eol` -> `line_cntr`=0.
